// File: rtl/stream_transpose.sv
// +--------------------------------------------------------------------------+
// | stream_transpose                                                         |
// | Ping-pong framed matrix buffer: row-major in, transposed or unchanged out|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module stream_transpose #(
  parameter int ROW_SIZE   = 4,
  parameter int COL_SIZE   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_transpose,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_err
);

  localparam int c_n  = ROW_SIZE * COL_SIZE;
  localparam int c_aw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_rw = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int c_cw = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam logic [c_aw-1:0] c_last     = c_aw'(c_n - 1);
  localparam logic [c_rw-1:0] c_row_last = c_rw'(ROW_SIZE - 1);

  localparam logic [1:0] c_empty    = 2'd0;
  localparam logic [1:0] c_filling  = 2'd1;
  localparam logic [1:0] c_full     = 2'd2;
  localparam logic [1:0] c_draining = 2'd3;

  logic [1:0]            r_bstate [2];
  logic [1:0]            w_bstate_nxt [2];
  logic                  r_mode [2];
  logic                  r_init;
  logic                  r_wsel;
  logic                  r_rsel;
  logic                  r_obank;
  logic [c_aw-1:0]       r_wptr;
  logic [c_aw-1:0]       r_rptr;
  logic [c_rw-1:0]       r_trow;
  logic [c_cw-1:0]       r_tcol;
  logic [DATA_WIDTH-1:0] r_mem [2][c_n];
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic                  r_frame_err;

  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_wr_last;
  logic                  w_avail;
  logic                  w_hs;
  logic                  w_load;
  logic                  w_rd_last;
  logic                  w_free;
  logic [c_aw-1:0]       w_raddr;

  // Bank state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bstate[0] <= c_empty;
      r_bstate[1] <= c_empty;
    end else begin
      r_bstate[0] <= w_bstate_nxt[0];
      r_bstate[1] <= w_bstate_nxt[1];
    end
  end

  // Write, load and free never address the same bank in one cycle
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bstate_nxt[b] = r_bstate[b];
      if (w_acc && (r_wsel == b[0]))
        w_bstate_nxt[b] = w_wr_last ? c_full : c_filling;
      if (w_load && (r_rsel == b[0]) && (r_bstate[b] == c_full))
        w_bstate_nxt[b] = c_draining;
      if (w_free && (r_obank == b[0]))
        w_bstate_nxt[b] = c_empty;
    end
  end

  always_comb begin
    w_in_ready = r_init & ((r_bstate[r_wsel] == c_empty) | (r_bstate[r_wsel] == c_filling));
    w_acc      = in_valid & w_in_ready;
    w_wr_last  = (r_wptr == c_last);
    w_avail    = (r_bstate[r_rsel] == c_full) | (r_bstate[r_rsel] == c_draining);
    w_hs       = r_out_valid & out_ready;
    w_load     = w_avail & (~r_out_valid | out_ready);
    w_rd_last  = (r_rptr == c_last);
    w_free     = w_hs & r_out_last;
    // Transposed walk: row = k % ROW_SIZE, col = k / ROW_SIZE, kept as counters
    w_raddr    = r_mode[r_rsel] ? c_aw'(32'(r_trow) * COL_SIZE + 32'(r_tcol)) : r_rptr;
  end

  always_ff @(posedge clk) begin
    if (w_acc)
      r_mem[r_wsel][r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init      <= 1'b0;
      r_wsel      <= 1'b0;
      r_wptr      <= '0;
      r_mode[0]   <= 1'b0;
      r_mode[1]   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_init      <= 1'b1;
      r_frame_err <= w_acc & (in_last ^ w_wr_last);
      if (w_acc) begin
        if (r_wptr == '0)
          r_mode[r_wsel] <= cfg_transpose;
        if (w_wr_last) begin
          r_wptr <= '0;
          r_wsel <= ~r_wsel;
        end else begin
          r_wptr <= r_wptr + c_aw'(1);
        end
      end
    end
  end

  // Read select advances as soon as the last element is loaded, so the next
  // frame can follow without a bubble; r_obank remembers which bank to free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsel      <= 1'b0;
      r_obank     <= 1'b0;
      r_rptr      <= '0;
      r_trow      <= '0;
      r_tcol      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mem[r_rsel][w_raddr];
      r_out_last  <= w_rd_last;
      r_obank     <= r_rsel;
      if (w_rd_last) begin
        r_rptr <= '0;
        r_trow <= '0;
        r_tcol <= '0;
        r_rsel <= ~r_rsel;
      end else begin
        r_rptr <= r_rptr + c_aw'(1);
        if (r_trow == c_row_last) begin
          r_trow <= '0;
          r_tcol <= r_tcol + c_cw'(1);
        end else begin
          r_trow <= r_trow + c_rw'(1);
        end
      end
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire
